// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer on the CPU store/load path.
// Registers: CTRL @+0x0 ({IM, MODE[1:0], EN}), PRESET @+0x4, COUNT @+0x8 (read-only),
// and +0xC, which reads 0. The interrupt request is irq_pend & CTRL.IM.
// Optional feature: define TIMER_AUTO_RELOAD_EN to enable MODE 01 auto-reload.
// Without it, MODE is stored and read back, but every mode acts as one-shot.
// Bus handshake: there is no valid/ready pair. The slave is always ready.
// A write is accepted on any rising edge where we=1 and addr selects a register.
// A read is combinational, with zero latency and no side effects.
// o_dbg_state exposes the FSM state: 0 IDLE, 1 LOAD, 2 CNT, 3 INT.
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic             r_irq_pend;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;

  logic w_sel;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en_eff;
  logic w_reload;
  logic w_unused;

  assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ctrl   = w_sel & we & (addr[3:2] == 2'd0);
  assign w_wr_preset = w_sel & we & (addr[3:2] == 2'd1);
  // A CTRL write on this edge overrides EN for the running count.
  // Pausing therefore freezes COUNT at the value the CPU last saw.
  assign w_en_eff    = w_wr_ctrl ? wdata[0] : r_en;
  // Byte-lane bits carry no meaning for word registers.
  assign w_unused    = ^{addr[1:0], wdata};

`ifdef TIMER_AUTO_RELOAD_EN
  assign w_reload = (r_mode == 2'b01);
`else
  assign w_reload = 1'b0;
`endif

  assign irq         = r_irq_pend & r_im;
  assign o_dbg_state = r_state;

  // Read mux: depends only on addr and the registers, so it is zero-latency and side-effect free.
  always_comb begin
    rdata = 32'd0;
    if (w_sel) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, r_im, r_mode, r_en};
        2'd1:    rdata = 32'(r_preset);
        2'd2:    rdata = 32'(r_count);
        default: rdata = 32'd0;
      endcase
    end
  end

  // PRESET register: written only by the CPU. It feeds COUNT only in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= CNT_W'(wdata);
    end
  end

  // Countdown FSM and CTRL register. A CPU CTRL write is applied last, so it wins over the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_mode     <= 2'b00;
      r_im       <= 1'b0;
      r_irq_pend <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (w_en_eff) begin
            // The COUNT<=1 guard also stops the counter from wrapping below zero.
            if (r_count <= CNT_W'(1)) begin
              r_count    <= '0;
              r_state    <= S_INT;
              r_irq_pend <= 1'b1;
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
        end
        S_INT: begin
          if (w_reload) begin
            // Auto-reload: the request lasts only for the INT cycle.
            r_irq_pend <= 1'b0;
            r_state    <= w_en_eff ? S_LOAD : S_IDLE;
          end else begin
            // One-shot: stop. The request stays pending until CTRL is written.
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr_ctrl) begin
        r_en       <= wdata[0];
        r_mode     <= wdata[2:1];
        r_im       <= wdata[3];
        r_irq_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: self-checking bench for timer_device.
// Expected values come from closed-form timing rules.
// After an EN write at edge t, let Pe = max(PRESET,1):
//   LOAD follows at t+1, COUNT = PRESET after t+2, and COUNT falls by one per edge to 0 at t+Pe+2.
//   The interrupt appears at t+Pe+2.
//   In auto-reload mode the sequence repeats with period Pe+2.
module tb_timer_device;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_LOAD  = 2'd1;
  localparam logic [1:0]  ST_CNT   = 2'd2;
  localparam logic [1:0]  ST_INT   = 2'd3;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic        we    = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  timer_device #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .we          (we),
    .wdata       (wdata),
    .rdata       (rdata),
    .irq         (irq),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    we   = 1'b0;
    addr = a;
    #1;
    d    = rdata;
    addr = 32'd0;
  endtask

  function automatic logic [31:0] oneshot_count(int p, int k);
    if (k < 2) return 32'd0;
    if (p > k - 2) return 32'(p - (k - 2));
    return 32'd0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    rd(A_CTRL, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    rd(A_PRESET, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_preset got=%h exp=0", d); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", d); end
    checks++; if (irq !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_irq_state irq=%b st=%0d exp irq=0 st=0", irq, dbg_state);
    end
    // Reset in the middle of a count.
    bus_write(A_PRESET, 32'd9);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) step();
    rd(A_COUNT, d);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL reset_precount got=%0d exp=5", d); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_async_irq got=%b exp=0", irq); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_async_ctrl got=%h exp=0", d); end
    rd(A_PRESET, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_async_preset got=%h exp=0", d); end
    rd(A_COUNT, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_async_count got=%h exp=0", d); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      rd(A_COUNT, d);
      checks++; if (irq !== 1'b0 || d !== 32'd0 || dbg_state !== ST_IDLE) begin
        failures++; $display("FAIL reset_after irq=%b count=%0d st=%0d exp 0/0/0", irq, d, dbg_state);
      end
    end
  endtask

  task automatic test_one_shot(input int p);
    logic [31:0] d, e;
    int pe;
    pe = (p == 0) ? 1 : p;
    do_reset();
    bus_write(A_PRESET, 32'(p));
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= pe + 4; k++) exp_q.push_back(oneshot_count(p, k));
    for (int k = 1; k <= pe + 4; k++) begin
      step();
      e = exp_q.pop_front();
      rd(A_COUNT, d);
      checks++; if (d !== e) begin failures++; $display("FAIL oneshot_count p=%0d k=%0d got=%0d exp=%0d", p, k, d, e); end
      checks++; if (irq !== (k >= pe + 2)) begin
        failures++; $display("FAIL oneshot_irq p=%0d k=%0d got=%b exp=%b", p, k, irq, (k >= pe + 2));
      end
      rd(A_CTRL, d);
      e = (k < pe + 3) ? 32'h9 : 32'h8;
      checks++; if (d !== e) begin failures++; $display("FAIL oneshot_ctrl p=%0d k=%0d got=%h exp=%h", p, k, d, e); end
    end
    bus_write(A_CTRL, 32'h0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_clear p=%0d got=%b exp=0", p, irq); end
  endtask

  task automatic test_auto_reload(input int p);
    logic [31:0] d, e_cnt, e_ctrl;
    logic        e_irq;
    int pe, per, m;
    pe  = (p == 0) ? 1 : p;
    per = pe + 2;
    do_reset();
    bus_write(A_PRESET, 32'(p));
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 3 * per + 2; k++) begin
      step();
      m = (k - 1) % per;
`ifdef TIMER_AUTO_RELOAD_EN
      e_cnt  = (m == 0 || m == per - 1) ? 32'd0 : 32'(p - (m - 1));
      e_irq  = (m == per - 1);
      e_ctrl = 32'hB;
`else
      e_cnt  = oneshot_count(p, k);
      e_irq  = (k >= pe + 2);
      e_ctrl = (k < pe + 3) ? 32'hB : 32'hA;
`endif
      rd(A_COUNT, d);
      checks++; if (d !== e_cnt) begin failures++; $display("FAIL reload_count p=%0d k=%0d got=%0d exp=%0d m=%0d", p, k, d, e_cnt, m); end
      checks++; if (irq !== e_irq) begin failures++; $display("FAIL reload_irq p=%0d k=%0d got=%b exp=%b", p, k, irq, e_irq); end
      rd(A_CTRL, d);
      checks++; if (d !== e_ctrl) begin failures++; $display("FAIL reload_ctrl p=%0d k=%0d got=%h exp=%h", p, k, d, e_ctrl); end
    end
  endtask

  task automatic test_pause();
    logic [31:0] d, e;
    int p;
    p = $urandom_range(12, 20);
    do_reset();
    bus_write(A_PRESET, 32'(p));
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= p - 4; k++) step();
    rd(A_COUNT, d);
    checks++; if (d !== 32'd6) begin failures++; $display("FAIL pause_reach p=%0d got=%0d exp=6", p, d); end
    bus_write(A_CTRL, 32'h8);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      rd(A_COUNT, d);
      checks++; if (d !== 32'd6 || irq !== 1'b0) begin
        failures++; $display("FAIL pause_hold k=%0d count=%0d irq=%b exp 6/0", k, d, irq);
      end
    end
    bus_write(A_CTRL, 32'h9);
    for (int j = 0; j <= 5; j++) exp_q.push_back(32'(5 - j));
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) step();
      e = exp_q.pop_front();
      rd(A_COUNT, d);
      checks++; if (d !== e) begin failures++; $display("FAIL pause_resume j=%0d got=%0d exp=%0d", j, d, e); end
      checks++; if (irq !== (j == 5)) begin failures++; $display("FAIL pause_irq j=%0d got=%b exp=%b", j, irq, (j == 5)); end
    end
  endtask

  task automatic test_edges();
    logic [31:0] d, np;
    logic        saw_int;
    // PRESET==0: INT two cycles after LOAD.
    do_reset();
    bus_write(A_PRESET, 32'd0);
    bus_write(A_CTRL, 32'h9);
    step();
    checks++; if (dbg_state !== ST_LOAD) begin failures++; $display("FAIL p0_load got=%0d exp=%0d", dbg_state, ST_LOAD); end
    step();
    checks++; if (dbg_state !== ST_CNT || irq !== 1'b0) begin
      failures++; $display("FAIL p0_cnt st=%0d irq=%b exp %0d/0", dbg_state, irq, ST_CNT);
    end
    step();
    checks++; if (dbg_state !== ST_INT || irq !== 1'b1) begin
      failures++; $display("FAIL p0_int st=%0d irq=%b exp %0d/1", dbg_state, irq, ST_INT);
    end
    // PRESET write mid-count, with IM=0.
    do_reset();
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 4; k++) step();
    rd(A_COUNT, d);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL im0_count got=%0d exp=8", d); end
    np = 32'($urandom_range(50, 200));
    bus_write(A_PRESET, np);
    rd(A_COUNT, d);
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL preset_inflight got=%0d exp=7", d); end
    rd(A_PRESET, d);
    checks++; if (d !== np) begin failures++; $display("FAIL preset_readback got=%0d exp=%0d", d, np); end
    saw_int = 1'b0;
    for (int k = 6; k <= 14; k++) begin
      step();
      if (dbg_state == ST_INT) saw_int = 1'b1;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL im0_irq k=%0d got=%b exp=0", k, irq); end
    end
    checks++; if (saw_int !== 1'b1) begin failures++; $display("FAIL im0_int_seen got=%b exp=1", saw_int); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL im0_en_clr got=%h exp=0", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d, p, a;
    do_reset();
    p = $urandom;
    bus_write(A_PRESET, p);
    bus_write(A_CTRL, 32'h6);
    bus_write(BASE + 32'h10, $urandom);
    rd(A_PRESET, d);
    checks++; if (d !== p) begin failures++; $display("FAIL dec_out_preset got=%h exp=%h", d, p); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h6) begin failures++; $display("FAIL dec_out_ctrl got=%h exp=6", d); end
    bus_write(A_RSVD, $urandom);
    rd(A_RSVD, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL dec_rsvd got=%h exp=0", d); end
    rd(A_PRESET, d);
    checks++; if (d !== p) begin failures++; $display("FAIL dec_rsvd_preset got=%h exp=%h", d, p); end
    // The low two address bits are ignored.
    bus_write(A_PRESET + 32'd3, 32'h1234);
    rd(A_PRESET, d);
    checks++; if (d !== 32'h1234) begin failures++; $display("FAIL dec_lowbits got=%h exp=1234", d); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      if (a[31:4] == BASE[31:4]) a[20] = ~a[20];
      rd(a, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL dec_unsel addr=%h got=%h exp=0", a, d); end
    end
    // A COUNT write while running is ignored.
    do_reset();
    bus_write(A_PRESET, 32'd20);
    bus_write(A_CTRL, 32'h1);
    for (int k = 1; k <= 4; k++) step();
    bus_write(A_COUNT, 32'hFFFF);
    rd(A_COUNT, d);
    checks++; if (d !== 32'd17) begin failures++; $display("FAIL dec_count_wr got=%0d exp=17", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_one_shot(3);
    test_one_shot($urandom_range(0, 12));
    test_one_shot($urandom_range(1, 12));
    test_auto_reload(2);
    test_auto_reload($urandom_range(0, 5));
    test_pause();
    test_edges();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
